// File: rtl/hmnoc_cluster_load_ctrl_if.sv
// Load-controller bundle: GLB read ports, west-router controls and PE-cluster handshake.
// master = load controller, slave = GLB/router/cluster side.
interface hmnoc_cluster_load_ctrl_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 9
);
   logic                  cfg_start;
   logic                  busy;
   logic                  done;
   logic                  read_req_wght;
   logic [ADDR_WIDTH-1:0] r_addr_wght;
   logic                  west_enable_i_wght;
   logic [3:0]            router_mode_wght;
   logic                  load_en_wght;
   logic                  read_req_iact;
   logic [ADDR_WIDTH-1:0] r_addr_iact;
   logic                  west_enable_i_iact;
   logic [3:0]            router_mode_iact;
   logic                  load_en_act;
   logic                  load_done;
   logic                  start;
   logic                  compute_done;
   logic                  read_req_psum;
   logic [ADDR_WIDTH-1:0] r_addr_psum;
   logic [DATA_WIDTH-1:0] r_data_psum;
   logic                  psum_valid;
   logic [DATA_WIDTH-1:0] psum_data;
   logic                  timeout_err;

   modport master (
      input  cfg_start, load_done, compute_done, r_data_psum,
      output busy, done,
      output read_req_wght, r_addr_wght, west_enable_i_wght, router_mode_wght, load_en_wght,
      output read_req_iact, r_addr_iact, west_enable_i_iact, router_mode_iact, load_en_act,
      output start, read_req_psum, r_addr_psum, psum_valid, psum_data, timeout_err
   );

   modport slave (
      output cfg_start, load_done, compute_done, r_data_psum,
      input  busy, done,
      input  read_req_wght, r_addr_wght, west_enable_i_wght, router_mode_wght, load_en_wght,
      input  read_req_iact, r_addr_iact, west_enable_i_iact, router_mode_iact, load_en_act,
      input  start, read_req_psum, r_addr_psum, psum_valid, psum_data, timeout_err
   );
endinterface

// File: rtl/hmnoc_cluster_load_ctrl.sv
// Sequencer upstream of the west cluster: streams weights then iacts GLB->router->PEs, starts compute, drains psums.
// Latency: k**2 + a**2 + 4 load cycles, then load_done/compute_done waits, then NUM_PSUM + 2 drain cycles to done.
// Backpressure: none on the streams; only load_done/compute_done stall. LOAD_CTRL_TIMEOUT_EN adds a compute watchdog.
module hmnoc_cluster_load_ctrl #(
   parameter int DATA_WIDTH     = 16,
   parameter int ADDR_WIDTH     = 9,
   parameter int kernel_size    = 3,
   parameter int act_size       = 5,
   parameter int NUM_PSUM       = 9,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input logic                       clk,
   input logic                       reset,
   hmnoc_cluster_load_ctrl_if.master lc
);
   localparam int W_CNT = kernel_size * kernel_size;
   localparam int A_CNT = act_size * act_size;
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE    = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] W_LAST      = ADDR_WIDTH'(W_CNT);
   localparam logic [ADDR_WIDTH-1:0] A_LAST      = ADDR_WIDTH'(A_CNT);
   localparam logic [ADDR_WIDTH-1:0] P_LAST_ADDR = ADDR_WIDTH'(NUM_PSUM - 1);
   localparam logic [3:0]            MODE_WEST   = 4'd3;

   // Stream addresses run one past the element count (prefetch), so the count itself must fit.
   generate
      if (A_CNT >= (1 << ADDR_WIDTH) || W_CNT >= (1 << ADDR_WIDTH) || NUM_PSUM < 1 ||
          NUM_PSUM > (1 << ADDR_WIDTH) || TIMEOUT_CYCLES < 1 || DATA_WIDTH < 1) begin : g_bad_cfg
         $error("hmnoc_cluster_load_ctrl: counts do not fit ADDR_WIDTH or bad parameter");
      end
   endgenerate

   typedef enum logic [3:0] {
      IDLE, W_PRE, W_STREAM, W_GAP, A_PRE, A_STREAM, A_GAP, A_WAIT,
      START, COMPUTE, P_READ, P_LAST, DONE
   } state_t;

   typedef struct packed {
      logic                  busy;
      logic                  done;
      logic                  rd_w;
      logic [ADDR_WIDTH-1:0] addr_w;
      logic                  we_w;
      logic [3:0]            mode_w;
      logic                  ld_w;
      logic                  rd_a;
      logic [ADDR_WIDTH-1:0] addr_a;
      logic                  we_a;
      logic [3:0]            mode_a;
      logic                  ld_a;
      logic                  start;
      logic                  rd_p;
      logic [ADDR_WIDTH-1:0] addr_p;
   } ctl_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
   ctl_t                  ctl_q, ctl_nxt;
   logic                  rd_pend;
   logic                  psum_valid_q;
   logic [DATA_WIDTH-1:0] psum_data_q;

`ifdef LOAD_CTRL_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] tmr;
   logic          timeout_q;
   logic          wd_expire;
   assign wd_expire = (tmr == TMR_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tmr       <= '0;
         timeout_q <= 1'b0;
      end else begin
         tmr <= (state == COMPUTE) ? tmr + TW'(1) : '0;
         if (state == COMPUTE && !lc.compute_done && wd_expire)
            timeout_q <= 1'b1;
         else if (state == IDLE && lc.cfg_start)
            timeout_q <= 1'b0;
      end
   end
   assign lc.timeout_err = timeout_q;
`else
   assign lc.timeout_err = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE:     if (lc.cfg_start) state_nxt = W_PRE;
         W_PRE:    begin state_nxt = W_STREAM; cnt_nxt = ADDR_ONE; end
         W_STREAM: begin
            if (cnt == W_LAST) begin state_nxt = W_GAP; cnt_nxt = '0; end
            else cnt_nxt = cnt + ADDR_ONE;
         end
         W_GAP:    state_nxt = A_PRE;
         A_PRE:    begin state_nxt = A_STREAM; cnt_nxt = ADDR_ONE; end
         A_STREAM: begin
            if (cnt == A_LAST) begin state_nxt = A_GAP; cnt_nxt = '0; end
            else cnt_nxt = cnt + ADDR_ONE;
         end
         A_GAP, A_WAIT: state_nxt = lc.load_done ? START : A_WAIT;
         START:    state_nxt = COMPUTE;
         COMPUTE: begin
            if (lc.compute_done) begin state_nxt = P_READ; cnt_nxt = '0; end
`ifdef LOAD_CTRL_TIMEOUT_EN
            else if (wd_expire) state_nxt = DONE;
`endif
         end
         P_READ: begin
            if (cnt == P_LAST_ADDR) begin state_nxt = P_LAST; cnt_nxt = '0; end
            else cnt_nxt = cnt + ADDR_ONE;
         end
         P_LAST:   state_nxt = DONE;
         DONE:     state_nxt = IDLE;
         default:  begin state_nxt = IDLE; cnt_nxt = '0; end
      endcase

      // Outputs decode the next state so every port comes straight from a flop.
      ctl_nxt      = '0;
      ctl_nxt.busy = (state_nxt != IDLE);
      case (state_nxt)
         W_PRE:    begin ctl_nxt.rd_w = 1'b1; ctl_nxt.addr_w = cnt_nxt; end
         W_STREAM: begin
            ctl_nxt.rd_w   = 1'b1;
            ctl_nxt.addr_w = cnt_nxt;
            ctl_nxt.we_w   = 1'b1;
            ctl_nxt.ld_w   = (cnt_nxt == ADDR_ONE);
         end
         A_PRE:    begin ctl_nxt.rd_a = 1'b1; ctl_nxt.addr_a = cnt_nxt; end
         A_STREAM: begin
            ctl_nxt.rd_a   = 1'b1;
            ctl_nxt.addr_a = cnt_nxt;
            ctl_nxt.we_a   = 1'b1;
            ctl_nxt.ld_a   = (cnt_nxt == ADDR_ONE);
         end
         START:    ctl_nxt.start = 1'b1;
         P_READ:   begin ctl_nxt.rd_p = 1'b1; ctl_nxt.addr_p = cnt_nxt; end
         DONE:     ctl_nxt.done = 1'b1;
         default:  ;
      endcase
      // Router modes stay on WEST from the first streamed word until the run ends.
      if (state_nxt inside {W_STREAM, W_GAP, A_PRE, A_STREAM, A_GAP, A_WAIT,
                            START, COMPUTE, P_READ, P_LAST, DONE})
         ctl_nxt.mode_w = MODE_WEST;
      if (state_nxt inside {A_STREAM, A_GAP, A_WAIT, START, COMPUTE, P_READ, P_LAST, DONE})
         ctl_nxt.mode_a = MODE_WEST;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         cnt          <= '0;
         ctl_q        <= '0;
         rd_pend      <= 1'b0;
         psum_valid_q <= 1'b0;
         psum_data_q  <= '0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         ctl_q        <= ctl_nxt;
         // GLB answers one cycle after the request; capture on that cycle.
         rd_pend      <= ctl_q.rd_p;
         psum_valid_q <= rd_pend;
         if (rd_pend) psum_data_q <= lc.r_data_psum;
      end
   end

   assign lc.busy               = ctl_q.busy;
   assign lc.done               = ctl_q.done;
   assign lc.read_req_wght      = ctl_q.rd_w;
   assign lc.r_addr_wght        = ctl_q.addr_w;
   assign lc.west_enable_i_wght = ctl_q.we_w;
   assign lc.router_mode_wght   = ctl_q.mode_w;
   assign lc.load_en_wght       = ctl_q.ld_w;
   assign lc.read_req_iact      = ctl_q.rd_a;
   assign lc.r_addr_iact        = ctl_q.addr_a;
   assign lc.west_enable_i_iact = ctl_q.we_a;
   assign lc.router_mode_iact   = ctl_q.mode_a;
   assign lc.load_en_act        = ctl_q.ld_a;
   assign lc.start              = ctl_q.start;
   assign lc.read_req_psum      = ctl_q.rd_p;
   assign lc.r_addr_psum        = ctl_q.addr_p;
   assign lc.psum_valid         = psum_valid_q;
   assign lc.psum_data          = psum_data_q;
endmodule

// File: tb/tb_hmnoc_cluster_load_ctrl.sv
// Bench: GLB/cluster environment model plus a timeline reference model compared every cycle.
module tb_hmnoc_cluster_load_ctrl;
   localparam int DW = 16, AW = 9, KS = 3, AS = 5, NP = 9, TO = 16;
   localparam int WN = KS * KS, AN = AS * AS, OE = AS - KS + 1;
   localparam int T_AGAP = WN + AN + 3;
`ifdef LOAD_CTRL_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   hmnoc_cluster_load_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   hmnoc_cluster_load_ctrl #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .kernel_size(KS), .act_size(AS),
      .NUM_PSUM(NP), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .reset(reset),
      .lc(bus)
   );

   int n_chk = 0, n_err = 0;
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Environment: three 1-cycle-latency GLBs and a cluster that records what arrives on the west ports.
   logic [DW-1:0] wght_mem[512];
   logic [DW-1:0] iact_mem[512];
   logic [DW-1:0] psum_mem[512];
   logic [DW-1:0] w_rd = '0, a_rd = '0;
   logic [DW-1:0] w_got[$], a_got[$], psum_got[$];

   always @(posedge clk) begin
      if (bus.west_enable_i_wght) w_got.push_back(w_rd);
      if (bus.west_enable_i_iact) a_got.push_back(a_rd);
      if (bus.read_req_wght) w_rd <= wght_mem[bus.r_addr_wght];
      if (bus.read_req_iact) a_rd <= iact_mem[bus.r_addr_iact];
      if (bus.read_req_psum) bus.r_data_psum <= psum_mem[bus.r_addr_psum];
   end

   // Reference timeline: t counts cycles from W_PRE; phase boundaries follow from the element counts.
   bit run = 0, to_pend = 0, exp_to = 0;
   int t = 0, t_start = -1, t_pread = -1, t_done = -1, n_done = 0;

   always @(negedge clk) begin : cmp
      bit e_rrw, e_wew, e_lew, e_rra, e_wea, e_lea, e_rrp, e_pv;
      int e_aw, e_aa, e_ap, e_mw, e_ma, pidx;
      logic [DW-1:0] e_pd, a_pd;
      if (!reset) begin run = 0; exp_to = 0; end
      e_rrw = 0; e_wew = 0; e_lew = 0; e_rra = 0; e_wea = 0; e_lea = 0; e_rrp = 0; e_pv = 0;
      e_aw = 0; e_aa = 0; e_ap = 0; e_mw = 0; e_ma = 0; pidx = 0; e_pd = '0;
      if (run) begin
         if (t == 0) exp_to = 0;
         e_rrw = (t <= WN);               e_aw = e_rrw ? t : 0;
         e_wew = (t >= 1 && t <= WN);     e_lew = (t == 1);
         e_mw  = (t >= 1) ? 3 : 0;
         e_rra = (t >= WN + 2 && t <= WN + 2 + AN);  e_aa = e_rra ? t - (WN + 2) : 0;
         e_wea = (t >= WN + 3 && t <= WN + 2 + AN);  e_lea = (t == WN + 3);
         e_ma  = (t >= WN + 3) ? 3 : 0;
         if (t_pread >= 0) begin
            e_rrp = (t >= t_pread && t <= t_pread + NP - 1);
            e_ap  = e_rrp ? t - t_pread : 0;
            e_pv  = (t >= t_pread + 2 && t <= t_pread + NP + 1);
            pidx  = t - t_pread - 2;
            if (e_pv) e_pd = psum_mem[pidx];
         end
         if (t == t_done && to_pend) exp_to = 1;
      end
      a_pd = bus.psum_valid ? bus.psum_data : '0;
      check("ctrl{busy,done,start,to}", {bus.busy, bus.done, bus.start, bus.timeout_err},
            {run, run && t == t_done, run && t == t_start, exp_to});
      check("wght{rd,addr,en,mode,ld}",
            {bus.read_req_wght, bus.r_addr_wght, bus.west_enable_i_wght, bus.router_mode_wght, bus.load_en_wght},
            {e_rrw, AW'(e_aw), e_wew, 4'(e_mw), e_lew});
      check("iact{rd,addr,en,mode,ld}",
            {bus.read_req_iact, bus.r_addr_iact, bus.west_enable_i_iact, bus.router_mode_iact, bus.load_en_act},
            {e_rra, AW'(e_aa), e_wea, 4'(e_ma), e_lea});
      check("psum{rd,addr,vld,dat}", {bus.read_req_psum, bus.r_addr_psum, bus.psum_valid, a_pd},
            {e_rrp, AW'(e_ap), e_pv, e_pd});
      if (bus.psum_valid) psum_got.push_back(bus.psum_data);
      if (bus.done) n_done++;
      if (reset) begin
         if (!run) begin
            if (bus.cfg_start) begin
               run = 1; t = 0; t_start = -1; t_pread = -1; t_done = -1; to_pend = 0;
            end
         end else begin
            if (t_start < 0 && t >= T_AGAP && bus.load_done) t_start = t + 1;
            if (t_start >= 0 && t > t_start && t_done < 0) begin
               if (bus.compute_done) begin
                  t_pread = t + 1;
                  t_done  = t + NP + 2;
               end else if (TO_EN && (t - t_start == TO)) begin
                  t_done  = t + 1;
                  to_pend = 1;
               end
            end
            if (t == t_done) run = 0;
            else t++;
         end
      end
   end

   task automatic fill_psum();
      if (w_got.size() == WN && a_got.size() == AN) begin
         for (int r = 0; r < OE; r++)
            for (int c = 0; c < OE; c++) begin
               int s = 0;
               for (int i = 0; i < KS; i++)
                  for (int j = 0; j < KS; j++)
                     s += int'(w_got[i*KS+j]) * int'(a_got[(r+i)*AS+c+j]);
               psum_mem[r*OE+c] = DW'(s);
            end
      end
   endtask

   // cd_delay < 0 leaves compute_done stuck low.
   task automatic run_layer(input int ld_delay, input int cd_delay, input bit busy_pulse);
      int  d0;
      bit  ok;
      w_got.delete(); a_got.delete(); psum_got.delete();
      d0 = n_done;
      @(posedge clk); #1 bus.cfg_start = 1'b1;
      @(posedge clk); #1 bus.cfg_start = 1'b0;
      ok = 0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(posedge clk); #1;
         ok = (a_got.size() == AN);
      end
      check("iact_stream_complete", ok, 1);
      if (busy_pulse) begin
         bus.cfg_start = 1'b1;
         @(posedge clk); #1 bus.cfg_start = 1'b0;
      end
      if (ld_delay > 0) begin
         repeat (ld_delay) @(posedge clk);
         #1;
      end
      bus.load_done = 1'b1;
      ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = bus.start;
      end
      check("start_seen", ok, 1);
      fill_psum();
      if (cd_delay >= 0) begin
         repeat (cd_delay) @(posedge clk);
         #1 bus.compute_done = 1'b1;
      end
      ok = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         ok = bus.done;
      end
      check("done_seen", ok, 1);
      @(posedge clk); #1;
      bus.compute_done = 1'b0;
      bus.load_done    = 1'b0;
      repeat (3) @(posedge clk);
      #1 check("one_done_per_run", 64'(n_done - d0), 1);
   endtask

   initial begin
      bus.cfg_start    = 1'b0;
      bus.load_done    = 1'b0;
      bus.compute_done = 1'b0;
      for (int i = 0; i < 512; i++) begin
         wght_mem[i] = (i < WN) ? DW'(1) : DW'(16'hdead);
         iact_mem[i] = (i < AN) ? DW'(i + 1) : DW'(16'hbeef);
         psum_mem[i] = '0;
      end
      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      check("reset_busy", bus.busy, 0);
      check("reset_psum_data", bus.psum_data, 0);
      repeat (2) @(posedge clk);

      // Reset in the middle of the weight stream.
      #1 bus.cfg_start = 1'b1;
      @(posedge clk); #1 bus.cfg_start = 1'b0;
      repeat (4) @(posedge clk);
      #1 check("mid_stream_en_before_reset", bus.west_enable_i_wght, 1);
      reset = 1'b0;
      #1 check("async_reset_busy", bus.busy, 0);
      check("async_reset_wght", {bus.read_req_wght, bus.r_addr_wght, bus.router_mode_wght}, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      // Full layer: weights all 1, iacts 1..25, immediate load_done.
      run_layer(0, 3, 1'b0);
      check("w_count", w_got.size(), WN);
      for (int i = 0; i < WN && i < w_got.size(); i++) check("w_value", w_got[i], 1);
      check("a_count", a_got.size(), AN);
      for (int i = 0; i < AN && i < a_got.size(); i++) check("a_value", a_got[i], i + 1);
      check("psum_beats", psum_got.size(), NP);
      if (psum_got.size() == NP) begin
         check("psum_first", psum_got[0], 63);
         check("psum_row2_col0", psum_got[6], 153);
         check("psum_last", psum_got[8], 171);
      end

      // load_done withheld in A_WAIT, plus a cfg_start while busy.
      run_layer(20, 5, 1'b1);
      check("psum_beats_run2", psum_got.size(), NP);

`ifdef LOAD_CTRL_TIMEOUT_EN
      run_layer(0, -1, 1'b0);
      check("timeout_sticky", bus.timeout_err, 1);
      check("timeout_no_psum", psum_got.size(), 0);
`endif

      // A following normal run must clear any watchdog flag and drain again.
      run_layer(2, 1, 1'b0);
      check("psum_beats_run_last", psum_got.size(), NP);
      check("timeout_cleared", bus.timeout_err, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
